// File: rtl/frame_scheduler.sv
// frame_scheduler: once-per-frame shadow latch of player data plus the round sequencer.
// Build option FRAME_SCHEDULER_HITSTOP_EN adds the hit-stop FREEZE state and health-drop detection.
//   state   | meaning
//   RUN     | normal play, game_tick issued on every frame
//   FREEZE  | hit-stop after a health drop, game ticks suppressed
//   WIN     | win screen held, winstate frozen, no ticks
//   RESTART | single-cycle round_restart pulse, shadow health back to full
module frame_scheduler #(
    parameter int unsigned WIN_HOLD_FRAMES   = 180,
    parameter int unsigned HIT_FREEZE_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [9:0]  p1_x_in,
    input  logic [9:0]  p1_y_in,
    input  logic [9:0]  p2_x_in,
    input  logic [9:0]  p2_y_in,
    input  logic [3:0]  p1_state_in,
    input  logic [3:0]  p2_state_in,
    input  logic [3:0]  p1_health_in,
    input  logic [3:0]  p2_health_in,
    output logic [9:0]  p1_x,
    output logic [9:0]  p1_y,
    output logic [9:0]  p2_x,
    output logic [9:0]  p2_y,
    output logic [3:0]  p1_state,
    output logic [3:0]  p2_state,
    output logic [3:0]  p1_health,
    output logic [3:0]  p2_health,
    output logic [1:0]  winstate,
    output logic        game_tick,
    output logic        round_restart,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {RUN, FREEZE, WIN, RESTART} state_t;

    localparam logic [3:0] FULL_HEALTH = 4'd8;
    localparam logic [7:0] WIN_LOAD    = 8'(WIN_HOLD_FRAMES - 1);
`ifdef FRAME_SCHEDULER_HITSTOP_EN
    localparam logic [7:0] FREEZE_LOAD = 8'(HIT_FREEZE_FRAMES - 1);
`else
    localparam int unsigned freeze_frames_unused = HIT_FREEZE_FRAMES;
`endif

    state_t      state_q;
    logic [7:0]  hold_q;
    logic [9:0]  p1_x_q, p1_y_q, p2_x_q, p2_y_q;
    logic [3:0]  p1_state_q, p2_state_q, p1_health_q, p2_health_q;
    logic [1:0]  winstate_q;
    logic        game_tick_q, round_restart_q;
    logic [15:0] frame_count_q;

    // winner code is directly {P2 dead, P1 dead}: 10 = P1 wins, 01 = P2 wins, 11 = draw
    logic [1:0]  winner_d;
    logic        any_dead_d;
    assign winner_d   = {p2_health_in == 4'd0, p1_health_in == 4'd0};
    assign any_dead_d = |winner_d;

`ifdef FRAME_SCHEDULER_HITSTOP_EN
    logic health_drop_d;
    assign health_drop_d = (p1_health_in < p1_health_q) || (p2_health_in < p2_health_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            hold_q          <= 8'd0;
            p1_x_q          <= 10'd0;
            p1_y_q          <= 10'd0;
            p2_x_q          <= 10'd0;
            p2_y_q          <= 10'd0;
            p1_state_q      <= 4'd0;
            p2_state_q      <= 4'd0;
            p1_health_q     <= FULL_HEALTH;
            p2_health_q     <= FULL_HEALTH;
            winstate_q      <= 2'b00;
            game_tick_q     <= 1'b0;
            round_restart_q <= 1'b0;
            frame_count_q   <= 16'd0;
        end else begin
            game_tick_q     <= 1'b0;
            round_restart_q <= 1'b0;
            if (state_q == RESTART) begin
                state_q     <= RUN;
                winstate_q  <= 2'b00;
                p1_health_q <= FULL_HEALTH;
                p2_health_q <= FULL_HEALTH;
            end else if (frame_start) begin
                p1_x_q        <= p1_x_in;
                p1_y_q        <= p1_y_in;
                p2_x_q        <= p2_x_in;
                p2_y_q        <= p2_y_in;
                p1_state_q    <= p1_state_in;
                p2_state_q    <= p2_state_in;
                p1_health_q   <= p1_health_in;
                p2_health_q   <= p2_health_in;
                frame_count_q <= frame_count_q + 16'd1;
                case (state_q)
                    RUN: begin
                        if (any_dead_d) begin
                            state_q    <= WIN;
                            winstate_q <= winner_d;
                            hold_q     <= WIN_LOAD;
                        end
`ifdef FRAME_SCHEDULER_HITSTOP_EN
                        else if (health_drop_d) begin
                            state_q <= FREEZE;
                            hold_q  <= FREEZE_LOAD;
                        end
`endif
                        else begin
                            game_tick_q <= 1'b1;
                        end
                    end
`ifdef FRAME_SCHEDULER_HITSTOP_EN
                    FREEZE: begin
                        if (any_dead_d) begin
                            state_q    <= WIN;
                            winstate_q <= winner_d;
                            hold_q     <= WIN_LOAD;
                        end else if (hold_q == 8'd0) begin
                            state_q     <= RUN;
                            game_tick_q <= 1'b1;
                        end else begin
                            hold_q <= hold_q - 8'd1;
                        end
                    end
`endif
                    WIN: begin
                        if (hold_q == 8'd0) begin
                            state_q         <= RESTART;
                            round_restart_q <= 1'b1;
                        end else begin
                            hold_q <= hold_q - 8'd1;
                        end
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign p1_x          = p1_x_q;
    assign p1_y          = p1_y_q;
    assign p2_x          = p2_x_q;
    assign p2_y          = p2_y_q;
    assign p1_state      = p1_state_q;
    assign p2_state      = p2_state_q;
    assign p1_health     = p1_health_q;
    assign p2_health     = p2_health_q;
    assign winstate      = winstate_q;
    assign game_tick     = game_tick_q;
    assign round_restart = round_restart_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed round scenarios plus randomized frames against a frame-level model.
module tb_frame_scheduler;

    localparam int WIN_HOLD   = 4;
    localparam int HIT_FREEZE = 8;
`ifdef FRAME_SCHEDULER_HITSTOP_EN
    localparam bit HITSTOP = 1'b1;
`else
    localparam bit HITSTOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  p1_x_in = '0, p1_y_in = '0, p2_x_in = '0, p2_y_in = '0;
    logic [3:0]  p1_state_in = '0, p2_state_in = '0;
    logic [3:0]  p1_health_in = 4'd8, p2_health_in = 4'd8;
    logic [9:0]  p1_x, p1_y, p2_x, p2_y;
    logic [3:0]  p1_state, p2_state, p1_health, p2_health;
    logic [1:0]  winstate;
    logic        game_tick, round_restart;
    logic [15:0] frame_count;

    frame_scheduler #(
        .WIN_HOLD_FRAMES  (WIN_HOLD),
        .HIT_FREEZE_FRAMES(HIT_FREEZE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .p1_x_in      (p1_x_in),
        .p1_y_in      (p1_y_in),
        .p2_x_in      (p2_x_in),
        .p2_y_in      (p2_y_in),
        .p1_state_in  (p1_state_in),
        .p2_state_in  (p2_state_in),
        .p1_health_in (p1_health_in),
        .p2_health_in (p2_health_in),
        .p1_x         (p1_x),
        .p1_y         (p1_y),
        .p2_x         (p2_x),
        .p2_y         (p2_y),
        .p1_state     (p1_state),
        .p2_state     (p2_state),
        .p1_health    (p1_health),
        .p2_health    (p2_health),
        .winstate     (winstate),
        .game_tick    (game_tick),
        .round_restart(round_restart),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what the renderer and game logic should see after each frame.
    logic [9:0]  m_p1x, m_p1y, m_p2x, m_p2y;
    logic [3:0]  m_p1s, m_p2s, m_p1h, m_p2h;
    logic [1:0]  m_win;
    logic [15:0] m_count;
    bit          in_win, frozen, exp_tick, exp_restart;
    int          win_left, frozen_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".p1_x"}, 32'(p1_x), 32'(m_p1x));
        check({tag, ".p1_y"}, 32'(p1_y), 32'(m_p1y));
        check({tag, ".p2_x"}, 32'(p2_x), 32'(m_p2x));
        check({tag, ".p2_y"}, 32'(p2_y), 32'(m_p2y));
        check({tag, ".p1_state"}, 32'(p1_state), 32'(m_p1s));
        check({tag, ".p2_state"}, 32'(p2_state), 32'(m_p2s));
        check({tag, ".p1_health"}, 32'(p1_health), 32'(m_p1h));
        check({tag, ".p2_health"}, 32'(p2_health), 32'(m_p2h));
        check({tag, ".winstate"}, 32'(winstate), 32'(m_win));
        check({tag, ".game_tick"}, 32'(game_tick), 32'(exp_tick));
        check({tag, ".round_restart"}, 32'(round_restart), 32'(exp_restart));
        check({tag, ".frame_count"}, 32'(frame_count), 32'(m_count));
    endtask

    task automatic scramble_live();
        p1_x_in     = 10'($urandom);
        p1_y_in     = 10'($urandom);
        p2_x_in     = 10'($urandom);
        p2_y_in     = 10'($urandom);
        p1_state_in = 4'($urandom);
        p2_state_in = 4'($urandom);
        p1_health_in = 4'($urandom);
        p2_health_in = 4'($urandom);
    endtask

    task automatic model_reset();
        {m_p1x, m_p1y, m_p2x, m_p2y} = '0;
        {m_p1s, m_p2s} = '0;
        m_p1h = 4'd8;
        m_p2h = 4'd8;
        m_win = 2'b00;
        m_count = 16'd0;
        in_win = 1'b0;
        frozen = 1'b0;
        exp_tick = 1'b0;
        exp_restart = 1'b0;
    endtask

    // One frame as the spec describes it, given the live inputs presented at frame_start.
    task automatic model_frame();
        logic [3:0] prev1, prev2;
        prev1 = m_p1h;
        prev2 = m_p2h;
        m_p1x = p1_x_in;  m_p1y = p1_y_in;
        m_p2x = p2_x_in;  m_p2y = p2_y_in;
        m_p1s = p1_state_in;  m_p2s = p2_state_in;
        m_p1h = p1_health_in; m_p2h = p2_health_in;
        m_count = m_count + 16'd1;
        exp_tick = 1'b0;
        exp_restart = 1'b0;
        if (in_win) begin
            win_left--;
            if (win_left == 0) exp_restart = 1'b1;
        end else if (p1_health_in == 0 || p2_health_in == 0) begin
            in_win = 1'b1;
            frozen = 1'b0;
            win_left = WIN_HOLD;
            if (p1_health_in == 0 && p2_health_in == 0) m_win = 2'b11;
            else if (p2_health_in == 0)                 m_win = 2'b10;
            else                                        m_win = 2'b01;
        end else if (frozen) begin
            if (frozen_left == 0) begin
                frozen = 1'b0;
                exp_tick = 1'b1;
            end else begin
                frozen_left--;
            end
        end else if (HITSTOP && (p1_health_in < prev1 || p2_health_in < prev2)) begin
            frozen = 1'b1;
            frozen_left = HIT_FREEZE - 1;
        end else begin
            exp_tick = 1'b1;
        end
    endtask

    task automatic do_reset(input bit with_frame);
        @(negedge clk);
        scramble_live();
        rst = 1'b1;
        frame_start = with_frame;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        frame_start = 1'b0;
        check_outputs(with_frame ? "reset_fs" : "reset");
    endtask

    // Present a frame, check the latched result, then change live inputs mid-frame and recheck.
    task automatic do_frame(input logic [3:0] h1, input logic [3:0] h2);
        @(negedge clk);
        scramble_live();
        p1_health_in = h1;
        p2_health_in = h2;
        frame_start = 1'b1;
        model_frame();
        @(negedge clk);
        frame_start = 1'b0;
        check_outputs("frame");
        if (exp_restart) begin
            in_win = 1'b0;
            m_win = 2'b00;
            m_p1h = 4'd8;
            m_p2h = 4'd8;
        end
        exp_tick = 1'b0;
        exp_restart = 1'b0;
        @(negedge clk);
        scramble_live();
        check_outputs("midframe");
    endtask

    initial begin
        model_reset();
        do_reset(1'b0);

        // plain run: three ticks
        for (int i = 0; i < 3; i++) do_frame(4'd8, 4'd8);
        check("count_after_3", 32'(frame_count), 32'd3);

        // P2 takes a hit: freeze (if built) then resume
        do_frame(4'd8, 4'd7);
        for (int i = 0; i < 10; i++) do_frame(4'd8, 4'd7);

        // P2 knocked out: win display then restart
        do_frame(4'd8, 4'd0);
        check("winstate_p1", 32'(winstate), 32'b10);
        for (int i = 0; i < WIN_HOLD; i++) do_frame(4'd8, 4'd0);
        do_frame(4'd8, 4'd8);

        // draw, then P1 alone knocked out
        do_frame(4'd0, 4'd0);
        for (int i = 0; i < WIN_HOLD; i++) do_frame(4'd8, 4'd8);
        do_frame(4'd0, 4'd5);
        for (int i = 0; i < WIN_HOLD; i++) do_frame(4'd0, 4'd5);
        do_frame(4'd8, 4'd8);

        // reset in the middle of WIN, and reset coinciding with frame_start
        do_frame(4'd3, 4'd0);
        do_frame(4'd3, 4'd0);
        do_reset(1'b0);
        do_frame(4'd8, 4'd8);
        do_frame(4'd0, 4'd8);
        do_reset(1'b1);
        for (int i = 0; i < 2; i++) do_frame(4'd8, 4'd8);

        // frame_count wrap
        @(negedge clk);
        force dut.frame_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.frame_count_q;
        m_count = 16'hFFFE;
        @(negedge clk);
        check("count_preload", 32'(frame_count), 32'hFFFE);
        for (int i = 0; i < 3; i++) do_frame(4'd8, 4'd8);
        check("count_wrapped", 32'(frame_count), 32'd1);

        // randomized frames
        for (int i = 0; i < 80; i++) begin
            logic [3:0] h1, h2;
            h1 = ($urandom_range(0, 11) == 0) ? 4'd0 : 4'($urandom_range(1, 8));
            h2 = ($urandom_range(0, 11) == 0) ? 4'd0 : 4'($urandom_range(1, 8));
            do_frame(h1, h2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
